// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the sequential ALU.
// OP_DIV is only decoded when SEQ_ALU_DIV_EN is defined.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOT  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_ADD  = 4'b0110;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_LSL  = 4'b1010;
  localparam logic [3:0] OP_ASL  = 4'b1011;
  localparam logic [3:0] OP_LSR  = 4'b1100;
  localparam logic [3:0] OP_ASR  = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic cout;
    logic negative;
    logic zero;
    logic overflow;
  } flags_t;

  // Opcodes that run through the shared iterative unit instead of the 1-cycle datapath.
  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Issue-side request and writeback-side result handshake of the sequential ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             negative;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, a, b, sel, cin, out_ready,
    input  in_ready, out_valid, y, cout, negative, zero, overflow
  );

  modport slave (
    input  in_valid, a, b, sel, cin, out_ready,
    output in_ready, out_valid, y, cout, negative, zero, overflow
  );
endinterface

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiplier, one bit per cycle over WIDTH cycles.
// With SEQ_ALU_DIV_EN defined the same registers also run a restoring divide.
module seq_alu_iter import seq_alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
`ifdef SEQ_ALU_DIV_EN
  input  logic             div_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             hi_nz_o
);

  logic             busy_q, busy_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] hi_s, lo_s;
  logic [WIDTH:0]   mul_sum_s;
  logic             last_s;
`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH:0]   trial_s;
`endif

  assign last_s   = (cnt_q == SHW'(WIDTH - 1));
  assign done_o   = busy_q && last_s;
  // On the final iteration the top captures the step result directly.
  assign result_o = lo_s;
  assign hi_nz_o  = |hi_s;

  // One iteration: {hi,lo} shifts right with a conditional add, or left with a trial subtract.
  always_comb begin
    mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
`ifdef SEQ_ALU_DIV_EN
    rem_sh_s  = {hi_q, lo_q[WIDTH-1]};
    trial_s   = rem_sh_s - {1'b0, opd_q};
    if (div_q) begin
      hi_s = trial_s[WIDTH] ? rem_sh_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
      lo_s = {lo_q[WIDTH-2:0], ~trial_s[WIDTH]};
    end else begin
      hi_s = mul_sum_s[WIDTH:1];
      lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
    end
`else
    hi_s = mul_sum_s[WIDTH:1];
    lo_s = {mul_sum_s[0], lo_q[WIDTH-1:1]};
`endif
  end

  // Load operands on start, then iterate until the counter reaches WIDTH-1.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opd_d  = opd_q;
`ifdef SEQ_ALU_DIV_EN
    div_d  = div_q;
`endif
    if (start_i && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = {SHW{1'b0}};
      hi_d   = {WIDTH{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      div_d  = div_i;
      lo_d   = div_i ? a_i : b_i;
      opd_d  = div_i ? b_i : a_i;
`else
      lo_d   = b_i;
      opd_d  = a_i;
`endif
    end else if (busy_q) begin
      busy_d = !last_s;
      cnt_d  = cnt_q + SHW'(1'b1);
      hi_d   = hi_s;
      lo_d   = lo_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= {SHW{1'b0}};
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
      opd_q  <= {WIDTH{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opd_q  <= opd_d;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU between issue and writeback with registered result and flags.
// Defining SEQ_ALU_DIV_EN turns opcode 1110 into an unsigned divide.
module seq_alu import seq_alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready_s, accept_s, release_s, start_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH:0]   add_s, sub_s, shl_s;
  logic [WIDTH-1:0] res_y_s;
  flags_t           res_f_s;
  logic             iter_done_s, iter_hi_nz_s;
  logic [WIDTH-1:0] iter_y_s, mul_y_s;
  flags_t           mul_f_s;
`ifdef SEQ_ALU_DIV_EN
  logic             div_op_q, div_op_d;
  logic             bz_q, bz_d;
`endif

  assign in_ready_s = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign release_s  = out_valid_q && bus.out_ready;
  assign start_s    = accept_s && is_iter_op(bus.sel);
  assign sh_s       = bus.b[SHW-1:0];

  assign add_s = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
  assign sub_s = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
  // Bit WIDTH catches the last bit shifted out; it stays 0 for a zero amount.
  assign shl_s = {1'b0, bus.a} << sh_s;

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_s),
`ifdef SEQ_ALU_DIV_EN
    .div_i    (bus.sel == OP_DIV),
`endif
    .a_i      (bus.a),
    .b_i      (bus.b),
    .done_o   (iter_done_s),
    .result_o (iter_y_s),
    .hi_nz_o  (iter_hi_nz_s)
  );

  // Result and flags of every single-cycle opcode, from the live request.
  always_comb begin
    res_y_s = {WIDTH{1'b0}};
    res_f_s = flags_t'(4'b0000);
    case (bus.sel)
      OP_AND:  res_y_s = bus.a & bus.b;
      OP_OR:   res_y_s = bus.a | bus.b;
      OP_NOT:  res_y_s = ~bus.a;
      OP_NOR:  res_y_s = ~(bus.a | bus.b);
      OP_XOR:  res_y_s = bus.a ^ bus.b;
      OP_NAND: res_y_s = ~(bus.a & bus.b);
      OP_ADD: begin
        res_y_s          = add_s[WIDTH-1:0];
        res_f_s.cout     = add_s[WIDTH];
        res_f_s.negative = res_y_s[WIDTH-1];
        res_f_s.overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (res_y_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        res_y_s          = sub_s[WIDTH-1:0];
        res_f_s.cout     = sub_s[WIDTH];
        res_f_s.negative = res_y_s[WIDTH-1];
        res_f_s.overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (res_y_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_LSL, OP_ASL: begin
        res_y_s          = shl_s[WIDTH-1:0];
        res_f_s.cout     = shl_s[WIDTH];
        res_f_s.negative = res_y_s[WIDTH-1];
        res_f_s.overflow = (res_y_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_LSR:  res_y_s = bus.a >> sh_s;
      OP_ASR: begin
        res_y_s          = $unsigned($signed(bus.a) >>> sh_s);
        res_f_s.negative = res_y_s[WIDTH-1];
      end
      default: res_y_s = {WIDTH{1'b0}};
    endcase
    res_f_s.zero = (res_y_s == {WIDTH{1'b0}});
  end

  // Result and flags for the value finishing in the iterative unit.
  always_comb begin
    mul_y_s = iter_y_s;
    mul_f_s = flags_t'(4'b0000);
`ifdef SEQ_ALU_DIV_EN
    if (div_op_q) begin
      if (bz_q) begin
        mul_y_s          = {WIDTH{1'b1}};
        mul_f_s.overflow = 1'b1;
      end else begin
        mul_y_s = iter_y_s;
      end
    end else begin
      mul_f_s.cout = iter_hi_nz_s;
    end
`else
    mul_f_s.cout = iter_hi_nz_s;
`endif
    mul_f_s.negative = mul_y_s[WIDTH-1];
    mul_f_s.zero     = (mul_y_s == {WIDTH{1'b0}});
  end

  // Next state and output-register values for the two handshakes.
  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
`ifdef SEQ_ALU_DIV_EN
    div_op_d    = div_op_q;
    bz_d        = bz_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          if (start_s) begin
            state_d     = MUL;
            out_valid_d = 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_op_d    = (bus.sel == OP_DIV);
            bz_d        = (bus.b == {WIDTH{1'b0}});
`endif
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            y_d         = res_y_s;
            flags_d     = res_f_s;
          end
        end else if (release_s) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      MUL: begin
        if (iter_done_s) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          y_d         = mul_y_s;
          flags_d     = mul_f_s;
        end else begin
          state_d = MUL;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and registered result/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= {WIDTH{1'b0}};
      flags_q     <= flags_t'(4'b0000);
      out_valid_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_op_q    <= 1'b0;
      bz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
`ifdef SEQ_ALU_DIV_EN
      div_op_q    <= div_op_d;
      bz_q        <= bz_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.cout      = flags_q.cout;
  assign bus.negative  = flags_q.negative;
  assign bus.zero      = flags_q.zero;
  assign bus.overflow  = flags_q.overflow;

endmodule
